aes_round_sequencer: RTL and testbench

//  Iterative AES-128 encryption controller: accepts one plaintext block + cipher key, runs initial

---
 rtl/aes_pkg.sv | 72 +++++++
 rtl/aes_key_step.sv | 27 ++
 rtl/aes_round_sequencer.sv | 90 +++++++++
 tb/tb_aes_round_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM encoding, round constants, S-box and the
// combinational round primitives used by the sequencer and key schedule.
package aes_pkg;

    localparam int NR_AES128 = 10;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round 0 and anything past NR have no constant; the key step is unused there.
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        return (r >= 4'd1 && r <= 4'd10) ? RCON[r] : 8'h00;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:127] sub_bytes(input logic [0:127] s);
        logic [0:127] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[s[8*i +: 8]];
        return r;
    endfunction

    // Byte (row, col) sits at index row + 4*col; row r rotates left by r columns.
    function automatic logic [0:127] shift_rows(input logic [0:127] s);
        logic [0:127] r;
        for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
                r[8*(row + 4*col) +: 8] = s[8*(row + 4*((col + row) % 4)) +: 8];
        return r;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c + 8 +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            r[32*c +: 8]      = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[32*c + 8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: derives the next round key from the previous one.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [0:127] prev_key,
    input  logic [7:0]   rcon,
    output logic [0:127] next_key
);

    logic [0:31] w0, w1, w2, w3, temp, n0, n1, n2, n3;

    always_comb begin
        w0 = prev_key[0:31];
        w1 = prev_key[32:63];
        w2 = prev_key[64:95];
        w3 = prev_key[96:127];
        // RotWord then SubWord, with rcon folded into the leading byte
        temp = {SBOX[w3[8:15]], SBOX[w3[16:23]], SBOX[w3[24:31]], SBOX[w3[0:7]]};
        temp[0:7] = temp[0:7] ^ rcon;
        n0 = w0 ^ temp;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryptor: one round per clock, round keys generated on the fly,
// one block in flight, valid/ready handshakes on both sides.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:KEY_W-1] plaintext,
    input  logic [0:KEY_W-1] key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:KEY_W-1] ciphertext,
    output logic             busy,
    output logic [3:0]       round
);

    if (NR != NR_AES128 || KEY_W != 128) begin : g_bad_cfg
        $error("aes_round_sequencer supports only AES-128 (NR=10, KEY_W=128)");
    end

    localparam logic [3:0] NR_L = 4'(NR);

    fsm_t         fsm_q, fsm_d;
    logic [0:127] st_q, st_d, rk_q, rk_d;
    logic [3:0]   round_q, round_d;
    logic [0:127] next_key, shifted, round_out;
    logic         last_round;

    aes_key_step u_key_step (
        .prev_key (rk_q),
        .rcon     (rcon_of(round_q)),
        .next_key (next_key)
    );

    assign last_round = (round_q == NR_L);
    assign shifted    = shift_rows(sub_bytes(st_q));
    assign round_out  = (last_round ? shifted : mix_columns(shifted)) ^ next_key;

    always_comb begin
        fsm_d   = fsm_q;
        st_d    = st_q;
        rk_d    = rk_q;
        round_d = round_q;
        case (fsm_q)
            IDLE: if (in_valid) begin
                st_d    = plaintext ^ key;
                rk_d    = key;
                round_d = 4'd1;
                fsm_d   = ROUND;
            end
            ROUND: begin
                st_d = round_out;
                rk_d = next_key;
                if (last_round) fsm_d = DONE;
                else            round_d = round_q + 4'd1;
            end
            DONE: if (out_ready) begin
                fsm_d   = IDLE;
                round_d = 4'd0;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            st_q    <= '0;
            rk_q    <= '0;
            round_q <= 4'd0;
        end else begin
            fsm_q   <= fsm_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            round_q <= round_d;
        end
    end

    assign in_ready   = (fsm_q == IDLE);
    assign out_valid  = (fsm_q == DONE);
    assign busy       = (fsm_q != IDLE);
    assign round      = round_q;
    assign ciphertext = st_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer using FIPS-197 vectors and a ciphertext scoreboard.
module tb_aes_round_sequencer;

    localparam logic [127:0] C1_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_P  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_C  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [0:127] plaintext, key, ciphertext;
    logic [3:0]   round;

    int tests = 0;
    int fails = 0;
    logic [127:0] sb[$];

    aes_round_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy),
        .round      (round)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pop();
        if (sb.size() == 0) return 'x;
        return sb.pop_front();
    endfunction

    // Called at a negedge; returns one negedge after the accepting edge.
    task automatic send(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] ct);
        int n = 0;
        while (!in_ready && n < 40) begin step(); n++; end
        chk("in_ready_timeout", in_ready, 1'b1);
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        sb.push_back(ct);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin step(); n++; end
        chk("out_valid_timeout", out_valid, 1'b1);
    endtask

    task automatic recv(input string tag);
        int n;
        wait_valid(n);
        out_ready = 1'b1;
        chk(tag, ciphertext, pop());
        step();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, out_valid, 1'b0);
        chk({tag, "_ready_back"}, in_ready, 1'b1);
    endtask

    initial begin
        int n, cyc, hs1, acc2, got, idx;
        logic acc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        plaintext = '0; key = '0;
        step();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_ct", ciphertext, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_round", round, 4'd0);
        rst_n = 1'b1;
        step();

        // C.1 with latency: counting the accepting edge as 1, out_valid is seen after edge 11
        send(C1_P, C1_K, C1_C);
        wait_valid(n);
        chk("c1_latency", n + 1, 11);
        chk("c1_round_done", round, 4'd10);
        recv("c1_ct");
        chk("c1_round_idle", round, 4'd0);

        // App. B with round index stepping every cycle
        send(B_P, B_K, B_C);
        chk("b_round_1", round, 4'd1);
        chk("b_busy", busy, 1'b1);
        for (int r = 2; r <= 10; r++) begin
            step();
            chk("b_round_step", round, r);
        end
        step();
        chk("b_done_valid", out_valid, 1'b1);
        chk("b_done_round", round, 4'd10);
        recv("b_ct");

        // Backpressure: held for 20 cycles while a new block is offered and ignored
        send(B_P, B_K, B_C);
        wait_valid(n);
        plaintext = C1_P; key = C1_K; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("bp_ct_stable", ciphertext, B_C);
            chk("bp_valid_held", out_valid, 1'b1);
            chk("bp_in_ready_low", in_ready, 1'b0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_ct", ciphertext, pop());
        step();
        out_ready = 1'b0;
        chk("bp_valid_drop", out_valid, 1'b0);
        chk("bp_ready_back", in_ready, 1'b1);
        chk("bp_ct_kept", ciphertext, B_C);
        chk("bp_not_accepted", busy, 1'b0);

        // Back-to-back: in_valid held, out_ready held
        idx = 0; cyc = 0; hs1 = -1; acc2 = -1; got = 0;
        plaintext = B_P; key = B_K; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 60 && got < 2; i++) begin
            if (out_valid) begin
                chk("b2b_ct", ciphertext, pop());
                got++;
                if (got == 1) hs1 = cyc;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                sb.push_back(idx == 0 ? B_C : C1_C);
                if (idx == 1) acc2 = cyc;
            end
            step();
            cyc++;
            if (acc) begin
                idx++;
                if (idx == 1) begin plaintext = C1_P; key = C1_K; end
                else in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("b2b_count", got, 2);
        chk("b2b_gap", acc2 - hs1, 1);

        // Reset mid-round
        step();
        send(C1_P, C1_K, C1_C);
        n = 0;
        while (round != 4'd5 && n < 15) begin step(); n++; end
        chk("mr_reach_round5", round, 4'd5);
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", out_valid, 1'b0);
        chk("mr_ct", ciphertext, '0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_round", round, 4'd0);
        chk("mr_in_ready", in_ready, 1'b1);
        sb.delete();
        step();
        rst_n = 1'b1;
        step();
        send(C1_P, C1_K, C1_C);
        recv("mr_c1_ct");

        // Inputs altered right after the accepting edge
        send(C1_P, C1_K, C1_C);
        plaintext = B_P;
        key       = ~C1_K;
        recv("chg_c1_ct");

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
